ssram_ctrl: RTL and testbench

- Avalon-MM slave (responder) that serves bus-controller read and write transactions to a pair of pipelined synchronous SRAMs.
- Drives the SSRAM pins: ADSP-initiated single-word accesses, byte-lane writes, and two chip enables selected by the top address bit.
- Sits between the bus controller chipselect/read/write outputs and the shared SSRAM/flash address and data bus.
- The top level owns the tristate pad; this block supplies data-out, data-in and output-enable.

---
 rtl/ssram_ctrl.sv | 132 +++++++++++++
 tb/tb_ssram_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ssram_ctrl.sv
// Avalon-MM slave driving a pair of pipelined synchronous SRAMs with single-word ADSP accesses.
// Optional one-entry read cache when SSRAM_RDCACHE_EN is defined.
module ssram_ctrl #(
  parameter int ADDR_W       = 21,
  parameter int READ_LATENCY = 2
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [ADDR_W-1:0] avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  input  logic [3:0]        avs_s0_byteenable,
  output logic [31:0]       avs_s0_readdata,
  output logic              avs_s0_waitrequest,
  output logic [ADDR_W-2:0] ssram_addr,
  output logic [31:0]       ssram_dout,
  input  logic [31:0]       ssram_din,
  output logic              ssram_doe,
  output logic [3:0]        ssram_be_n,
  output logic              ssram_adsp_n,
  output logic              ssram0_ce_n,
  output logic              ssram1_ce_n,
  output logic              ssram_oe_n,
  output logic              ssram_we_n,
  output logic              ssram_adv_n,
  output logic              ssram_gw_n,
  output logic              ssram_adsc_n
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RWAIT, ACK} state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              is_wr_q;
  logic [1:0]        cnt_q;
  logic              req, hit, accept, capture;
  logic [31:0]       hit_data;

  assign req     = avs_s0_read | avs_s0_write;
  // A cache hit is served without latching, so the address pins stay still.
  assign accept  = (state == IDLE) && req && !hit;
  assign capture = (state == RWAIT) && (cnt_q == 2'd0);

`ifdef SSRAM_RDCACHE_EN
  logic              c_vld;
  logic [ADDR_W-1:0] c_tag;
  logic [31:0]       c_data;

  assign hit      = (state == IDLE) && avs_s0_read && !avs_s0_write && c_vld && (c_tag == avs_s0_address);
  assign hit_data = c_data;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      c_vld  <= 1'b0;
      c_tag  <= '0;
      c_data <= '0;
    end else if ((state == IDLE) && avs_s0_write) begin
      c_vld <= 1'b0;
    end else if (capture) begin
      c_vld  <= 1'b1;
      c_tag  <= addr_q;
      c_data <= ssram_din;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = ACK;
               else if (req) state_nxt = CMD;
      CMD:     state_nxt = is_wr_q ? WR : RWAIT;
      WR:      state_nxt = ACK;
      RWAIT:   if (cnt_q == 2'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= avs_s0_address;
        be_q    <= avs_s0_byteenable;
        wdata_q <= avs_s0_writedata;
        is_wr_q <= avs_s0_write;
      end
      if (state == CMD)                     cnt_q <= CNT_INIT;
      else if (state == RWAIT && cnt_q != 0) cnt_q <= cnt_q - 2'd1;
      if (capture)  rdata_q <= ssram_din;
      else if (hit) rdata_q <= hit_data;
    end
  end

  // Pin strobes decode straight from state so an async reset releases them at once.
  assign ssram_adsp_n       = !(state == CMD);
  assign ssram0_ce_n        = !((state == CMD) && !addr_q[ADDR_W-1]);
  assign ssram1_ce_n        = !((state == CMD) &&  addr_q[ADDR_W-1]);
  assign ssram_we_n         = !(state == WR);
  assign ssram_be_n         = (state == WR) ? ~be_q : 4'hF;
  assign ssram_doe          = (state == WR);
  assign ssram_oe_n         = !(state == RWAIT);
  assign ssram_addr         = addr_q[ADDR_W-2:0];
  assign ssram_dout         = wdata_q;
  assign ssram_adv_n        = 1'b1;
  assign ssram_gw_n         = 1'b1;
  assign ssram_adsc_n       = 1'b1;
  assign avs_s0_waitrequest = (state != ACK);
  assign avs_s0_readdata    = rdata_q;

endmodule

// File: tb/tb_ssram_ctrl.sv
// Directed bench for ssram_ctrl with a behavioural two-device pipelined SSRAM model.
module tb_ssram_ctrl;
  logic        clk, rst_n;
  logic [20:0] address;
  logic        read, write;
  logic [31:0] writedata, readdata, dout, din;
  logic [3:0]  byteenable, be_n;
  logic        waitrequest, doe, adsp_n, ce0_n, ce1_n, oe_n, we_n, adv_n, gw_n, adsc_n;
  logic [19:0] saddr;

  ssram_ctrl #(.ADDR_W(21), .READ_LATENCY(2)) dut (
    .csi_clk(clk), .rsi_reset_n(rst_n),
    .avs_s0_address(address), .avs_s0_read(read), .avs_s0_write(write),
    .avs_s0_writedata(writedata), .avs_s0_byteenable(byteenable),
    .avs_s0_readdata(readdata), .avs_s0_waitrequest(waitrequest),
    .ssram_addr(saddr), .ssram_dout(dout), .ssram_din(din), .ssram_doe(doe),
    .ssram_be_n(be_n), .ssram_adsp_n(adsp_n), .ssram0_ce_n(ce0_n), .ssram1_ce_n(ce1_n),
    .ssram_oe_n(oe_n), .ssram_we_n(we_n), .ssram_adv_n(adv_n), .ssram_gw_n(gw_n),
    .ssram_adsc_n(adsc_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SSRAM model: address/enable sampled on ADSP, data out two edges later.
  logic [31:0] mem [logic [20:0]];
  logic [20:0] m_key;
  logic [31:0] p1, p2, m_w;

  function automatic logic [31:0] rdm(input logic [20:0] k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!we_n) begin
      m_w = rdm(m_key);
      for (int b = 0; b < 4; b++) if (!be_n[b]) m_w[8*b +: 8] = dout[8*b +: 8];
      mem[m_key] = m_w;
    end
    if (!adsp_n) begin
      m_key <= {!ce1_n, saddr};
      p1    <= rdm({!ce1_n, saddr});
    end
    p2 <= p1;
  end
  assign din = oe_n ? 32'h0 : p2;

  int n_cmp = 0, n_err = 0, n_cont = 0;

  always @(negedge clk) if (rst_n && doe && !oe_n) n_cont++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle pin trace of the last transaction; index 1 is the cycle after the request cycle.
  logic        tr_adsp[32], tr_we[32], tr_oe[32], tr_doe[32], tr_ce0[32], tr_ce1[32], tr_wreq[32];
  logic [3:0]  tr_be[32];
  logic [31:0] tr_dout[32];
  logic [19:0] tr_addr[32];

  task automatic xfer(input logic [20:0] a, input logic rd, input logic wr, input logic [31:0] d,
                      input logic [3:0] be, input bit imm, input bit hold, output int lat);
    if (!imm) @(negedge clk);
    address = a; read = rd; write = wr; writedata = d; byteenable = be;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      tr_adsp[lat] = adsp_n; tr_we[lat] = we_n; tr_oe[lat] = oe_n; tr_doe[lat] = doe;
      tr_ce0[lat] = ce0_n; tr_ce1[lat] = ce1_n; tr_wreq[lat] = waitrequest;
      tr_be[lat] = be_n; tr_dout[lat] = dout; tr_addr[lat] = saddr;
    end while (waitrequest && lat < 20);
    if (waitrequest) chk("ack_timeout", 32'(lat), 32'd0);
    if (!hold) begin read = 1'b0; write = 1'b0; end
  endtask

  function automatic int count_low(input int upto, input bit use_oe);
    int n = 0;
    for (int i = 1; i <= upto; i++) if (use_oe ? !tr_oe[i] : !tr_adsp[i]) n++;
    return n;
  endfunction

  int lat, lat2, guard;

  initial begin
    rst_n = 1'b0; address = '0; read = 0; write = 0; writedata = '0; byteenable = '0;
    #12;
    chk("rst_wreq", 32'(waitrequest), 32'd1);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_strobes", {26'h0, adsp_n, ce0_n, ce1_n, oe_n, we_n, doe}, 32'h3E);
    chk("rst_be_n", 32'(be_n), 32'hF);
    chk("rst_addr_dout", {12'h0, saddr} | dout, 32'h0);
    chk("rst_tied", {29'h0, adv_n, gw_n, adsc_n}, 32'h7);
    @(negedge clk) rst_n = 1'b1;

    // Abort a write while we_n is low: everything must drop without a clock edge.
    @(negedge clk);
    address = 21'h50; write = 1'b1; writedata = 32'h12345678; byteenable = 4'hF;
    guard = 0;
    do begin @(negedge clk); guard++; end while (we_n && guard < 10);
    chk("midwr_we_seen", 32'(we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midwr_we_n", 32'(we_n), 32'd1);
    chk("midwr_doe", 32'(doe), 32'd0);
    chk("midwr_wreq", 32'(waitrequest), 32'd1);
    chk("midwr_be_n", 32'(be_n), 32'hF);
    write = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    xfer(21'h000010, 0, 1, 32'hDEADBEEF, 4'hF, 0, 0, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_adsp_c1", 32'(tr_adsp[1]), 32'd0);
    chk("wr_ce_c1", {30'h0, tr_ce0[1], tr_ce1[1]}, 32'h1);
    chk("wr_we_c2", 32'(tr_we[2]), 32'd0);
    chk("wr_be_c2", 32'(tr_be[2]), 32'h0);
    chk("wr_dout_c2", tr_dout[2], 32'hDEADBEEF);
    chk("wr_doe_c2", 32'(tr_doe[2]), 32'd1);
    chk("wr_mem", rdm(21'h000010), 32'hDEADBEEF);

    mem[21'h100010] = 32'hCAFEF00D;
    xfer(21'h100010, 1, 0, 32'h0, 4'hF, 0, 0, lat);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_data", readdata, 32'hCAFEF00D);
    chk("rd_ce_c1", {30'h0, tr_ce0[1], tr_ce1[1]}, 32'h2);
    chk("rd_addr_c1", 32'(tr_addr[1]), 32'h00010);
    chk("rd_oe_cnt", 32'(count_low(lat, 1)), 32'd2);

    mem[21'h20] = 32'h11223344;
    xfer(21'h20, 0, 1, 32'hAABBCCDD, 4'b0100, 0, 0, lat);
    chk("be_be_n_c2", 32'(tr_be[2]), 32'hB);
    chk("be_mem", rdm(21'h20), 32'h11BB3344);
    xfer(21'h20, 1, 0, 32'h0, 4'hF, 0, 0, lat);
    chk("be_readback", readdata, 32'h11BB3344);

    xfer(21'h30, 1, 1, 32'h55667788, 4'hF, 0, 0, lat);
    chk("rw_lat", 32'(lat), 32'd3);
    chk("rw_we_c2", 32'(tr_we[2]), 32'd0);
    chk("rw_no_oe", 32'(count_low(lat, 1)), 32'd0);
    chk("rw_mem", rdm(21'h30), 32'h55667788);

    xfer(21'h10, 1, 0, 32'h0, 4'hF, 0, 1, lat);
    chk("b2b_data1", readdata, 32'hDEADBEEF);
    xfer(21'h30, 1, 0, 32'h0, 4'hF, 1, 0, lat2);
    chk("b2b_gap_lat", 32'(lat2), 32'd5);
    chk("b2b_idle_c1", {30'h0, tr_wreq[1], tr_adsp[1]}, 32'h3);
    chk("b2b_adsp_c2", 32'(tr_adsp[2]), 32'd0);
    chk("b2b_data2", readdata, 32'h55667788);

    mem[21'h40] = 32'h0BADC0DE;
    xfer(21'h40, 1, 0, 32'h0, 4'hF, 0, 0, lat);
    chk("c_first_lat", 32'(lat), 32'd4);
    xfer(21'h40, 1, 0, 32'h0, 4'hF, 0, 0, lat);
`ifdef SSRAM_RDCACHE_EN
    chk("c_hit_lat", 32'(lat), 32'd1);
    chk("c_hit_adsp", 32'(count_low(lat, 0)), 32'd0);
`else
    chk("c_hit_lat", 32'(lat), 32'd4);
    chk("c_hit_adsp", 32'(count_low(lat, 0)), 32'd1);
`endif
    chk("c_hit_data", readdata, 32'h0BADC0DE);
    xfer(21'h44, 0, 1, 32'h00000001, 4'hF, 0, 0, lat);
    xfer(21'h40, 1, 0, 32'h0, 4'hF, 0, 0, lat);
    chk("c_inval_lat", 32'(lat), 32'd4);
    chk("c_inval_data", readdata, 32'h0BADC0DE);

    chk("contention", 32'(n_cont), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
